up_frame_sequencer: RTL

// Frame-level controller for the up-sampling datapath. Starts a frame when PS sets UPSTAT.UPSTART

---
 rtl/up_frame_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/up_frame_sequencer.sv
// up_frame_sequencer
// ------------------
// Frame-level controller for the up-sampling datapath.
//   - Starts a frame when PS sets UPSTAT.UPSTART (UPEND must be clear).
//   - Gates the AXI-Stream handshakes into and out of the core so that exactly
//     IN_BEATS input beats and OUT_BEATS output beats pass per frame.
//   - At end of frame, writes UPSTAT = {UPEND=1, UPSTART=0} over the register
//     file PL write port. Then it waits for PS to clear UPEND.
// Data buses do not pass through this block. Only valid/ready/last do.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   crf_ac_UPSTART/UPEND      UPSTAT[0]/UPSTAT[1] from the register file
//   crf_ac_wbusy              PL write port busy (a PS write has priority)
//   ac_crf_wrt/waddr/wdata    PL write request towards the register file
//   ac_crf_processing         high while a frame is running
//   s_axis_tvalid/tready      upstream input handshake (gated)
//   core_i_tvalid/tready      core input handshake
//   core_o_tvalid/tready      core output handshake
//   m_axis_tvalid/tready      downstream output handshake (gated)
//   m_axis_tlast              marks the last output beat of the frame
module up_frame_sequencer #(
  parameter int CRF_ADDR_WIDTH = 32,
  parameter int CRF_DATA_WIDTH = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int IN_BEATS       = 518400,
  parameter int OUT_BEATS      = 8294400,
  parameter logic [CRF_ADDR_WIDTH-1:0] UPSTAT_ADDR = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      crf_ac_UPSTART,
  input  logic                      crf_ac_UPEND,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      ac_crf_processing,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic                      core_i_tvalid,
  input  logic                      core_i_tready,
  input  logic                      core_o_tvalid,
  output logic                      core_o_tready,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_WREND   = 2'd2;
  localparam logic [1:0] S_WAITCLR = 2'd3;

  localparam logic [CNT_WIDTH-1:0] IN_LIM   = CNT_WIDTH'(IN_BEATS);
  localparam logic [CNT_WIDTH-1:0] OUT_LIM  = CNT_WIDTH'(OUT_BEATS);
  localparam logic [CNT_WIDTH-1:0] OUT_LAST = CNT_WIDTH'(OUT_BEATS - 1);

  // UPEND=1, UPSTART=0
  localparam logic [CRF_DATA_WIDTH-1:0] UPEND_WORD = CRF_DATA_WIDTH'(2);

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_in_cnt;
  logic [CNT_WIDTH-1:0] r_out_cnt;

  logic w_run;
  logic w_in_open;
  logic w_out_open;
  logic w_in_fire;
  logic w_out_fire;
  logic w_done;

  assign w_run      = (r_state == S_RUN);
  assign w_in_open  = w_run && (r_in_cnt < IN_LIM);
  assign w_out_open = w_run && (r_out_cnt < OUT_LIM);

  // Zero-latency gates. A closed gate forces both valid and ready low.
  // So no beat can slip through once a counter has reached its limit.
  assign core_i_tvalid = s_axis_tvalid & w_in_open;
  assign s_axis_tready = core_i_tready & w_in_open;
  assign m_axis_tvalid = core_o_tvalid & w_out_open;
  assign core_o_tready = m_axis_tready & w_out_open;
  assign m_axis_tlast  = m_axis_tvalid & (r_out_cnt == OUT_LAST);

  assign w_in_fire  = s_axis_tvalid & s_axis_tready;
  assign w_out_fire = m_axis_tvalid & m_axis_tready;

  // Completion is judged on the registered counts. The frame therefore
  // stays in RUN for one cycle after the final beat.
  assign w_done = (r_in_cnt == IN_LIM) && (r_out_cnt == OUT_LIM);

  assign ac_crf_processing = w_run;
  assign ac_crf_wrt        = (r_state == S_WREND);
  assign ac_crf_waddr      = UPSTAT_ADDR;
  // The data word is held at zero outside a write request.
  // This keeps every output except the address quiet after reset.
  assign ac_crf_wdata      = ac_crf_wrt ? UPEND_WORD : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (crf_ac_UPSTART && !crf_ac_UPEND) begin
            r_state   <= S_RUN;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end
        end
        S_RUN: begin
          if (!crf_ac_UPSTART) begin
            // PS abort takes priority over a frame that just completed.
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
          end else begin
            if (w_done) begin
              r_state <= S_WREND;
            end
            // The limit checks are redundant with the gates. They keep the
            // counters from wrapping even if the gating is changed later.
            if (w_in_fire && (r_in_cnt != IN_LIM)) begin
              r_in_cnt <= r_in_cnt + 1'b1;
            end
            if (w_out_fire && (r_out_cnt != OUT_LIM)) begin
              r_out_cnt <= r_out_cnt + 1'b1;
            end
          end
        end
        S_WREND: begin
          // The request is held while the port is busy with a PS write.
          // It is accepted on the first non-busy edge.
          if (!crf_ac_wbusy) begin
            r_state <= S_WAITCLR;
          end
        end
        S_WAITCLR: begin
          if (!crf_ac_UPEND) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
